// File: rtl/cmd_resp_rx_pkg.sv
// ----------------------------------------------------------------------------
// cmd_resp_rx_pkg
// Shared SD CMD-line definitions: frame lengths, CRC7 polynomial, receiver
// state encoding and a single-bit CRC7 step used by the serial CRC block.
// ----------------------------------------------------------------------------
package cmd_resp_rx_pkg;

    localparam int         SHORT_RESP_LEN = 48;   // R1/R3/R6/R7
    localparam int         LONG_RESP_LEN  = 136;  // R2
    localparam logic [6:0] CRC7_POLY      = 7'h09; // x^7 + x^3 + 1

    // The shift register only has to hold frame bits 8..134 of an R2 frame.
    // Everything a short frame needs (bits 2..46) also fits in this width.
    localparam int         SHREG_W        = 127;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECV       = 2'd2,
        ST_DONE       = 2'd3
    } rx_state_e;

    // One serial CRC7 step, MSB of the register is the first bit transmitted.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/cmd_resp_rx_crc7.sv
// ----------------------------------------------------------------------------
// crc7
// Serial CRC7 (x^7+x^3+1, init 0). Shared between the CMD TX and RX paths.
// Ports:
//   clk    in   clock
//   rst    in   synchronous reset, active-low
//   clr_i  in   clear register to 0 (wins over en_i)
//   en_i   in   fold din_i into the CRC this cycle
//   din_i  in   serial data bit
//   crc_o  out  current CRC value
// ----------------------------------------------------------------------------
module crc7
    import cmd_resp_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, din_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/cmd_resp_rx.sv
// ----------------------------------------------------------------------------
// cmd_resp_rx
// SD CMD-line response receiver. After arming, waits for a start bit, shifts
// in a 48-bit or 136-bit (R2) response, checks transmission bit, CRC7 and end
// bit, and reports the result with a one-cycle done pulse.
// Ports:
//   clk, rst          clock / synchronous active-low reset
//   start_i           arm (only honoured in IDLE)
//   long_i, no_crc_i  frame type, sampled with start_i
//   cmd_i             sampled CMD line bit
//   busy_o            not in IDLE
//   done_o            one-cycle result pulse
//   timeout_o, crc_err_o, end_err_o, tx_err_o   status flags
//   resp_index_o      header index (6'h3F for R2)
//   resp_o            argument (short) or CID/CSD bits 127:1 (R2)
// ----------------------------------------------------------------------------
module cmd_resp_rx
    import cmd_resp_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         long_i,
    input  logic         no_crc_i,
    input  logic         cmd_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic         tx_err_o,
    output logic [5:0]   resp_index_o,
    output logic [127:0] resp_o
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > LONG_RESP_LEN) ? TIMEOUT_CYCLES : LONG_RESP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_RESP_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_RESP_LEN - 1);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHREG_W-1:0] shreg_q, shreg_d;
    logic               long_q, long_d;
    logic               no_crc_q, no_crc_d;
    logic               timeout_q, timeout_d;
    logic               crc_err_q, crc_err_d;
    logic               end_err_q, end_err_d;
    logic               tx_err_q, tx_err_d;
    logic [5:0]         idx_q, idx_d;
    logic [127:0]       resp_q, resp_d;

    logic               crc_clr, crc_en;
    logic [6:0]         crc_val;
    logic [CNT_W-1:0]   last_bit;

    crc7 u_crc7 (
        .clk   (clk),
        .rst   (rst),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .din_i (cmd_i),
        .crc_o (crc_val)
    );

    assign last_bit = long_q ? LONG_LAST : SHORT_LAST;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        long_d    = long_q;
        no_crc_d  = no_crc_q;
        timeout_d = timeout_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        tx_err_d  = tx_err_q;
        idx_d     = idx_q;
        resp_d    = resp_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    long_d    = long_i;
                    no_crc_d  = no_crc_i;
                    timeout_d = 1'b0;
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                    tx_err_d  = 1'b0;
                    cnt_d     = '0;
                    shreg_d   = '0;
                    crc_clr   = 1'b1;
                    state_d   = ST_WAIT_START;
                end
            end

            ST_WAIT_START: begin
                if (!cmd_i) begin
                    // Start bit is part of the CRC only for short frames.
                    crc_en  = !long_q;
                    shreg_d = {shreg_q[SHREG_W-2:0], cmd_i};
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RECV;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    resp_d    = '0;
                    idx_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RECV: begin
                shreg_d = {shreg_q[SHREG_W-2:0], cmd_i};
                cnt_d   = cnt_q + CNT_W'(1);

                if (cnt_q == CNT_W'(1) && cmd_i) begin
                    tx_err_d = 1'b1;
                end

                if (long_q) begin
                    crc_en = (cnt_q >= CNT_W'(8)) && (cnt_q <= CNT_W'(127));
                end else begin
                    crc_en = (cnt_q <= CNT_W'(39));
                end

                if (cnt_q == last_bit) begin
                    // shreg_q[k] holds frame bit (L-2-k) here: the received
                    // CRC sits in [6:0] for both frame types.
                    if (!cmd_i) begin
                        end_err_d = 1'b1;
                    end
                    if (!no_crc_q && (crc_val != shreg_q[6:0])) begin
                        crc_err_d = 1'b1;
                    end
                    if (long_q) begin
                        idx_d  = 6'h3F;
                        resp_d = {shreg_q, 1'b0};
                    end else begin
                        idx_d  = shreg_q[44:39];
                        resp_d = {96'd0, shreg_q[38:7]};
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            long_q    <= 1'b0;
            no_crc_q  <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            tx_err_q  <= 1'b0;
            idx_q     <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            long_q    <= long_d;
            no_crc_q  <= no_crc_d;
            timeout_q <= timeout_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            tx_err_q  <= tx_err_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign timeout_o    = timeout_q;
    assign crc_err_o    = crc_err_q;
    assign end_err_o    = end_err_q;
    assign tx_err_o     = tx_err_q;
    assign resp_index_o = idx_q;
    assign resp_o       = resp_q;

endmodule
